// File: rtl/alu_issue_ctrl_pkg.sv
// =============================================================================
// Module      : alu_issue_ctrl_pkg
// Description : Shared constants, instruction field layout, FSM states and
//               decode helpers for the ALU issue controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package alu_issue_ctrl_pkg;

    localparam int REG_FILE_WIDTH = 32;

    localparam int c_instr_w = 32;
    localparam int c_op_w    = 4;
    localparam int c_reg_w   = 5;

    localparam int c_op_lsb = 28;
    localparam int c_rd_lsb = 23;
    localparam int c_ra_lsb = 18;
    localparam int c_rb_lsb = 13;

    localparam logic [c_op_w-1:0] ALU_OP_ADD = 4'b0000;
    localparam logic [c_op_w-1:0] ALU_OP_SUB = 4'b0001;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [c_op_w-1:0]  op;
        logic [c_reg_w-1:0] rd;
        logic [c_reg_w-1:0] ra;
        logic [c_reg_w-1:0] rb;
    } dec_t;

    // Takes only the meaningful upper slice; bits below rb are don't-care.
    function automatic dec_t decode(input logic [c_instr_w-1:c_rb_lsb] hi);
        dec_t d;
        d.op = hi[c_op_lsb +: c_op_w];
        d.rd = hi[c_rd_lsb +: c_reg_w];
        d.ra = hi[c_ra_lsb +: c_reg_w];
        d.rb = hi[c_rb_lsb +: c_reg_w];
        return d;
    endfunction

    function automatic logic is_alu_op(input logic [c_op_w-1:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
// =============================================================================
// Module      : alu_issue_ctrl_if
// Description : Instruction, ALU and writeback signals of the issue controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface alu_issue_ctrl_if
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = REG_FILE_WIDTH
);
    logic [c_instr_w-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [c_op_w-1:0]    alu_op;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_zero;
    logic                 wb_valid;
    logic [c_reg_w-1:0]   wb_rd;
    logic [DATA_W-1:0]    wb_data;
    logic                 zero_flag;
    logic                 err;

    modport master (
        input  instr, instr_valid, alu_result, alu_zero,
        output instr_ready, alu_op, alu_a, alu_b,
               wb_valid, wb_rd, wb_data, zero_flag, err
    );

    modport slave (
        output instr, instr_valid, alu_result, alu_zero,
        input  instr_ready, alu_op, alu_a, alu_b,
               wb_valid, wb_rd, wb_data, zero_flag, err
    );

endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl_regfile.sv
// =============================================================================
// Module      : alu_issue_ctrl_regfile
// Description : NUM_REGS x DATA_W register file, two async read ports, one
//               sync write port, r0 hardwired to zero, sync reset clear.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_issue_ctrl_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_ra_addr,
    output logic [DATA_W-1:0] o_ra_data,
    input  logic [ADDR_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_ra_data = (i_ra_addr == '0) ? '0 : r_mem[i_ra_addr];
    assign o_rb_data = (i_rb_addr == '0) ? '0 : r_mem[i_rb_addr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// =============================================================================
// Module      : alu_issue_ctrl
// Description : Issue/execute/writeback controller driving an external
//               combinational ALU. Optional macro ALU_FWD_EN selects operand
//               forwarding; otherwise a RAW interlock stalls issue.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W   = REG_FILE_WIDTH,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.master bus
);

    localparam int c_aw = $clog2(NUM_REGS);

    state_t              r_state;
    state_t              w_state_nxt;
    dec_t                w_dec;
    logic                w_legal;
    logic                w_hazard;
    logic                w_ready;
    logic                w_err;
    logic                w_accept;
    logic [DATA_W-1:0]   w_rf_a;
    logic [DATA_W-1:0]   w_rf_b;
    logic [DATA_W-1:0]   w_opa;
    logic [DATA_W-1:0]   w_opb;
    logic                w_unused_bits;

    logic                r_idex_valid;
    logic [c_op_w-1:0]   r_idex_op;
    logic [c_reg_w-1:0]  r_idex_rd;
    logic [DATA_W-1:0]   r_idex_a;
    logic [DATA_W-1:0]   r_idex_b;

    logic                r_exwb_valid;
    logic [c_reg_w-1:0]  r_exwb_rd;
    logic [DATA_W-1:0]   r_exwb_data;
    logic                r_exwb_zero;
    logic                r_zero_flag;

    assign w_dec         = decode(bus.instr[c_instr_w-1:c_rb_lsb]);
    assign w_legal       = is_alu_op(w_dec.op);
    assign w_unused_bits = ^bus.instr[c_rb_lsb-1:0];

    alu_issue_ctrl_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_ra_addr (w_dec.ra[c_aw-1:0]),
        .o_ra_data (w_rf_a),
        .i_rb_addr (w_dec.rb[c_aw-1:0]),
        .o_rb_data (w_rf_b),
        .i_we      (r_exwb_valid),
        .i_wa      (r_exwb_rd[c_aw-1:0]),
        .i_wd      (r_exwb_data)
    );

`ifdef ALU_FWD_EN
    assign w_hazard = 1'b0;

    // Older (WB) source first so the newer EX source overrides it.
    always_comb begin
        w_opa = w_rf_a;
        w_opb = w_rf_b;
        if ((w_dec.ra != '0) && r_exwb_valid && (r_exwb_rd == w_dec.ra)) begin
            w_opa = r_exwb_data;
        end
        if ((w_dec.ra != '0) && r_idex_valid && (r_idex_rd == w_dec.ra)) begin
            w_opa = bus.alu_result;
        end
        if ((w_dec.rb != '0) && r_exwb_valid && (r_exwb_rd == w_dec.rb)) begin
            w_opb = r_exwb_data;
        end
        if ((w_dec.rb != '0) && r_idex_valid && (r_idex_rd == w_dec.rb)) begin
            w_opb = bus.alu_result;
        end
    end
`else
    assign w_opa = w_rf_a;
    assign w_opb = w_rf_b;

    // Hold issue until every in-flight producer of ra/rb has reached the file.
    assign w_hazard =
        ((w_dec.ra != '0) &&
         ((r_idex_valid && (r_idex_rd == w_dec.ra)) ||
          (r_exwb_valid && (r_exwb_rd == w_dec.ra)))) ||
        ((w_dec.rb != '0) &&
         ((r_idex_valid && (r_idex_rd == w_dec.rb)) ||
          (r_exwb_valid && (r_exwb_rd == w_dec.rb))));
`endif

    assign w_accept = bus.instr_valid & w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready = ~w_hazard;
                if (bus.instr_valid && !w_hazard && !w_legal) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_err = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex_valid <= 1'b0;
            r_idex_op    <= '0;
            r_idex_rd    <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_exwb_valid <= 1'b0;
            r_exwb_rd    <= '0;
            r_exwb_data  <= '0;
            r_exwb_zero  <= 1'b0;
            r_zero_flag  <= 1'b0;
        end else begin
            // An illegal op never enters ID/EX; operands keep their last value.
            r_idex_valid <= w_accept & w_legal;
            if (w_accept && w_legal) begin
                r_idex_op <= w_dec.op;
                r_idex_rd <= w_dec.rd;
                r_idex_a  <= w_opa;
                r_idex_b  <= w_opb;
            end
            r_exwb_valid <= r_idex_valid;
            if (r_idex_valid) begin
                r_exwb_rd   <= r_idex_rd;
                r_exwb_data <= bus.alu_result;
                r_exwb_zero <= bus.alu_zero;
            end
            if (r_exwb_valid) begin
                r_zero_flag <= r_exwb_zero;
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.alu_op      = r_idex_valid ? r_idex_op : '0;
    assign bus.alu_a       = r_idex_a;
    assign bus.alu_b       = r_idex_b;
    assign bus.wb_valid    = r_exwb_valid;
    assign bus.wb_rd       = r_exwb_rd;
    assign bus.wb_data     = r_exwb_data;
    assign bus.zero_flag   = r_zero_flag;
    assign bus.err         = w_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// =============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with an ALU stand-in
//               and an in-order architectural reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bias  = 32'd0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(32)) bus ();

    alu_issue_ctrl #(
        .DATA_W   (32),
        .NUM_REGS (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ALU stand-in: ADD carries a programmable offset so non-zero values exist.
    assign bus.alu_result = (bus.alu_op == 4'b0001) ? (bus.alu_a - bus.alu_b)
                                                    : (bus.alu_a + bus.alu_b + bias);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_BAD = 4'b0101;

    typedef struct {
        int unsigned acc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        zero;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_dep_stall;
    int unsigned cyc = 0;
    bit          mon_acc = 1'b0;

    ent_t        q[$];
    ent_t        e;
    ent_t        ex_e;
    bit          ex_found;
    logic [31:0] m_regs [32];
    logic        m_halt = 1'b0;
    logic        m_zf   = 1'b0;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_ra, m_rb;
    logic        exp_ready, exp_wb;
    logic [3:0]  exp_op;

    // Reference model: program-order register state, commit two cycles on.
    always @(negedge clk) begin
        cyc++;
        mon_acc = 1'b0;
        if (reset) begin
            q.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_halt = 1'b0;
            m_zf   = 1'b0;
        end else begin
            m_op = bus.instr[31:28];
            m_rd = bus.instr[27:23];
            m_ra = bus.instr[22:18];
            m_rb = bus.instr[17:13];
            exp_ready = !m_halt;
`ifndef ALU_FWD_EN
            foreach (q[i]) begin
                if (q[i].rd != 5'd0 && (q[i].rd == m_ra || q[i].rd == m_rb)) exp_ready = 1'b0;
            end
`endif
            checks++;
            if (bus.instr_ready !== exp_ready) begin
                errors++;
                $display("FAIL instr_ready cyc=%0d got=%b exp=%b", cyc, bus.instr_ready, exp_ready);
            end
            checks++;
            if (bus.err !== m_halt) begin
                errors++;
                $display("FAIL err cyc=%0d got=%b exp=%b", cyc, bus.err, m_halt);
            end
            exp_wb = (q.size() > 0) && (q[0].acc + 2 == cyc);
            checks++;
            if (bus.wb_valid !== exp_wb) begin
                errors++;
                $display("FAIL wb_valid cyc=%0d got=%b exp=%b", cyc, bus.wb_valid, exp_wb);
            end
            if (exp_wb) begin
                checks++;
                if (bus.wb_rd !== q[0].rd) begin
                    errors++;
                    $display("FAIL wb_rd cyc=%0d got=%0d exp=%0d", cyc, bus.wb_rd, q[0].rd);
                end
                checks++;
                if (bus.wb_data !== q[0].data) begin
                    errors++;
                    $display("FAIL wb_data cyc=%0d got=%h exp=%h", cyc, bus.wb_data, q[0].data);
                end
            end
            checks++;
            if (bus.zero_flag !== m_zf) begin
                errors++;
                $display("FAIL zero_flag cyc=%0d got=%b exp=%b", cyc, bus.zero_flag, m_zf);
            end
            ex_found = 1'b0;
            foreach (q[i]) begin
                if (q[i].acc + 1 == cyc) begin
                    ex_found = 1'b1;
                    ex_e     = q[i];
                end
            end
            exp_op = ex_found ? ex_e.op : 4'd0;
            checks++;
            if (bus.alu_op !== exp_op) begin
                errors++;
                $display("FAIL alu_op cyc=%0d got=%0d exp=%0d", cyc, bus.alu_op, exp_op);
            end
            if (ex_found) begin
                checks++;
                if (bus.alu_a !== ex_e.a || bus.alu_b !== ex_e.b) begin
                    errors++;
                    $display("FAIL alu_operands cyc=%0d got=%h/%h exp=%h/%h",
                             cyc, bus.alu_a, bus.alu_b, ex_e.a, ex_e.b);
                end
            end
            if (bus.instr_valid && exp_ready) begin
                mon_acc = 1'b1;
                if (m_op == OP_ADD || m_op == OP_SUB) begin
                    e.acc  = cyc;
                    e.op   = m_op;
                    e.rd   = m_rd;
                    e.a    = m_regs[m_ra];
                    e.b    = m_regs[m_rb];
                    e.data = (m_op == OP_SUB) ? (e.a - e.b) : (e.a + e.b + bias);
                    e.zero = (e.data == 32'd0);
                    q.push_back(e);
                    if (m_rd != 5'd0) m_regs[m_rd] = e.data;
                end else begin
                    m_halt = 1'b1;
                end
            end
            if (exp_wb) begin
                m_zf = q[0].zero;
                void'(q.pop_front());
            end
        end
    end

    task automatic apply_reset();
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.instr_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] ra,
                         input logic [4:0] rb, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        bus.instr       = {op, rd, ra, rb, 13'd0};
        bus.instr_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            #1;
            if (mon_acc) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout op=%0d rd=%0d got=no-accept exp=accept", op, rd);
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr = 32'd0;
        apply_reset();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.instr_ready); end
        checks++; if (bus.alu_op !== 4'd0) begin errors++; $display("FAIL rst_alu_op got=%0d exp=0", bus.alu_op); end
        checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("FAIL rst_alu_a got=%h exp=0", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd0) begin errors++; $display("FAIL rst_alu_b got=%h exp=0", bus.alu_b); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b exp=0", bus.wb_valid); end
        checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd got=%0d exp=0", bus.wb_rd); end
        checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL rst_wb_data got=%h exp=0", bus.wb_data); end
        checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL rst_zero_flag got=%b exp=0", bus.zero_flag); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_zero_ops();
        int s;
        bias = 32'd0;
        issue(OP_ADD, 5'd1, 5'd0, 5'd0, s);
        checks++; if (s !== 0) begin errors++; $display("FAIL zero_add_stall got=%0d exp=0", s); end
        issue(OP_SUB, 5'd2, 5'd0, 5'd0, s);
        checks++; if (s !== 0) begin errors++; $display("FAIL zero_sub_stall got=%0d exp=0", s); end
        idle(3);
        checks++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL zero_flag_set got=%b exp=1", bus.zero_flag); end
        checks++; if (bus.wb_rd !== 5'd2) begin errors++; $display("FAIL zero_last_rd got=%0d exp=2", bus.wb_rd); end
    endtask

    task automatic test_forward();
        int s;
        bias = 32'd5;
        issue(OP_ADD, 5'd3, 5'd0, 5'd0, s);
        idle(3);
        bias = 32'd7;
        issue(OP_ADD, 5'd4, 5'd0, 5'd0, s);
        idle(3);
        bias = 32'd0;
        issue(OP_ADD, 5'd5, 5'd3, 5'd4, s);
        checks++; if (s !== 0) begin errors++; $display("FAIL fwd_r5_stall got=%0d exp=0", s); end
        issue(OP_ADD, 5'd11, 5'd5, 5'd5, s);
        checks++; if (s !== exp_dep_stall) begin errors++; $display("FAIL fwd_r11_stall got=%0d exp=%0d", s, exp_dep_stall); end
        issue(OP_ADD, 5'd12, 5'd11, 5'd5, s);
        checks++; if (s !== exp_dep_stall) begin errors++; $display("FAIL fwd_r12_stall got=%0d exp=%0d", s, exp_dep_stall); end
        idle(3);
        checks++; if (bus.wb_data !== 32'd36) begin errors++; $display("FAIL fwd_chain got=%h exp=%h", bus.wb_data, 32'd36); end
    endtask

    task automatic test_sub_wrap();
        int s;
        issue(OP_SUB, 5'd6, 5'd4, 5'd3, s);
        issue(OP_SUB, 5'd7, 5'd3, 5'd4, s);
        checks++; if (s !== 0) begin errors++; $display("FAIL sub_stall got=%0d exp=0", s); end
        idle(3);
        checks++; if (bus.wb_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wrap got=%h exp=fffffffe", bus.wb_data); end
        checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL sub_zero got=%b exp=0", bus.zero_flag); end
    endtask

    task automatic test_r0_write();
        int s;
        bias = 32'd0;
        issue(OP_ADD, 5'd0, 5'd4, 5'd4, s);
        @(posedge clk);
        #1;
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0) begin
            errors++; $display("FAIL r0_commit got=%b/%0d exp=1/0", bus.wb_valid, bus.wb_rd);
        end
        checks++; if (bus.wb_data !== 32'd14) begin errors++; $display("FAIL r0_data got=%h exp=%h", bus.wb_data, 32'd14); end
        issue(OP_ADD, 5'd8, 5'd0, 5'd0, s);
        idle(3);
        checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL r0_read got=%h exp=0", bus.wb_data); end
    endtask

    task automatic test_illegal();
        int s;
        bias = 32'd0;
        issue(OP_ADD, 5'd9, 5'd4, 5'd0, s);
        issue(OP_BAD, 5'd10, 5'd0, 5'd0, s);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err got=%b exp=1", bus.err); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL ill_ready got=%b exp=0", bus.instr_ready); end
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd9 || bus.wb_data !== 32'd7) begin
            errors++; $display("FAIL ill_older_commit got=%b/%0d/%h exp=1/9/7", bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        bus.instr       = {OP_ADD, 5'd10, 5'd0, 5'd0, 13'd0};
        bus.instr_valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++; if (bus.err !== 1'b1 || bus.instr_ready !== 1'b0) begin
            errors++; $display("FAIL ill_hold got=%b/%b exp=1/0", bus.err, bus.instr_ready);
        end
        apply_reset();
        checks++; if (bus.err !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL ill_reset got=%b/%b exp=0/1", bus.err, bus.instr_ready);
        end
    endtask

    task automatic test_interlock();
        int s;
        bias = 32'd9;
        issue(OP_ADD, 5'd1, 5'd0, 5'd0, s);
        issue(OP_ADD, 5'd2, 5'd1, 5'd1, s);
        checks++; if (s !== exp_dep_stall) begin errors++; $display("FAIL dep_stall got=%0d exp=%0d", s, exp_dep_stall); end
        idle(3);
        checks++; if (bus.wb_rd !== 5'd2 || bus.wb_data !== 32'd27) begin
            errors++; $display("FAIL dep_result got=%0d/%h exp=2/%h", bus.wb_rd, bus.wb_data, 32'd27);
        end
    endtask

    task automatic test_mid_reset();
        int s;
        bias = 32'd5;
        issue(OP_ADD, 5'd3, 5'd0, 5'd0, s);
        idle(3);
        issue(OP_ADD, 5'd13, 5'd3, 5'd3, s);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop k=%0d got=%b exp=0", k, bus.wb_valid); end
            @(posedge clk);
            #1;
        end
        bias = 32'd0;
        issue(OP_ADD, 5'd14, 5'd3, 5'd0, s);
        idle(3);
        checks++; if (bus.wb_rd !== 5'd14 || bus.wb_data !== 32'd0) begin
            errors++; $display("FAIL midrst_rf_clear got=%0d/%h exp=14/0", bus.wb_rd, bus.wb_data);
        end
    endtask

    task automatic test_random();
        int   s;
        logic [3:0] op;
        for (int b = 0; b < 3; b++) begin
            bias = $urandom;
            for (int k = 0; k < 60; k++) begin
                op = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_SUB;
                issue(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), s);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.instr       = 32'd0;
        bus.instr_valid = 1'b0;
`ifdef ALU_FWD_EN
        exp_dep_stall = 0;
`else
        exp_dep_stall = 2;
`endif
        test_reset();
        test_zero_ops();
        test_forward();
        test_sub_wrap();
        test_r0_write();
        test_illegal();
        test_interlock();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface. Accepts 32-bit instruction words, decodes ALU ops, reads operands from a local register file and drives the combinational alu with op/regA/regB. Captures regD/zero into a writeback register and commits to the register file. Sits between fetch and the alu in the basic processor; 3-step pipeline (issue, execute, writeback) with one instruction per cycle.

Parameters:
DATA_W, `REG_FILE_WIDTH (32), operand/result width
NUM_REGS, 32, register file depth; index width = clog2(NUM_REGS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
instr  in  32  instruction word; [31:28] op, [27:23] rd, [22:18] ra, [17:13] rb, [12:0] ignored
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  block accepts instr this cycle
alu_op  out  4  op to alu
alu_a  out  DATA_W  operand A to alu
alu_b  out  DATA_W  operand B to alu
alu_result  in  DATA_W  alu regD, combinational from alu_op/a/b
alu_zero  in  1  alu zero flag
wb_valid  out  1  writeback committing this cycle
wb_rd  out  5  destination register of commit
wb_data  out  DATA_W  data being committed
zero_flag  out  1  zero flag of last committed instruction
err  out  1  sticky illegal-opcode flag

Behaviour:
- Clock is clk. Reset is reset: one clock, synchronous, active-high.
- Reset: all pipeline valids 0, ID/EX and EX/WB registers 0, alu_op 0, alu_a/alu_b 0, wb_valid 0, wb_rd 0, wb_data 0, zero_flag 0, err 0, FSM = RUN. Register file contents are cleared to 0.
- Accept = instr_valid & instr_ready.
- Cycle N (accept): decode; read ra/rb with forwarding; latch op/rd/operands into ID/EX at end of N.
- Cycle N+1: ID/EX drives alu_op/alu_a/alu_b; latch alu_result/alu_zero/rd into EX/WB at end of N+1.
- Cycle N+2: wb_valid=1; register file written and zero_flag updated at end of N+2.
- Latency from accept to commit is 2 cycles. Throughput is 1 per cycle.
- Register 0 reads as 0. Writes to rd=0 are discarded, but wb_valid still pulses and zero_flag still updates.
- Forwarding priority (newest first): EX stage (ID/EX rd, using alu_result), then WB stage (EX/WB rd, using wb_data), then register file. Never forward when rd=0.
- FSM states:
  - RUN: instr_ready=1.
  - HALT: instr_ready=0, err=1.
- RUN->HALT on accept of an op not in {ADD, SUB}. The illegal instruction does not enter ID/EX. Older in-flight instructions still complete.
- HALT is left only by reset.
- When ID/EX is empty: alu_op=0 and alu_a/alu_b hold their last values. EX/WB captures only when ID/EX is valid.
- Reset mid-operation: in-flight instructions are dropped and not committed.

Optional Feature:
ALU_FWD_EN
- Defined: full forwarding as above; instr_ready=1 in RUN.
- Undefined: no forwarding. An interlock holds instr_ready=0 while ra or rb (non-zero) matches a valid rd in ID/EX or EX/WB. The instruction is accepted the cycle after the producer commits.
- With the feature undefined, latency from accept to commit is unchanged, but back-to-back dependent instructions issue 3 cycles apart.

Decomposition:
- Shared header.vh holds:
  - `REG_FILE_WIDTH
  - op constants ALU_OP_ADD=4'b0000, ALU_OP_SUB=4'b0001
  - instruction field bit positions
  - FSM state encodings ST_RUN, ST_HALT
- One sub-module, regfile: NUM_REGS x DATA_W, two combinational read ports, one synchronous write port, r0 hardwired zero, synchronous reset clear.

Test Plan:
- ADD r1,r0,r0 then SUB r2,r0,r0 -> wb_valid at accept+2 with wb_data=0 and zero_flag=1; instr_ready stays 1.
- Preload r3=5 and r4=7 via preceding ADDs, then ADD r5,r3,r4 immediately after (ALU_FWD_EN) -> commit r5=12 with no stall; back-to-back dependents each take the EX forward path.
- SUB r6,r4,r3 followed by SUB r7,r3,r4 -> r6=2 (zero_flag=0) and r7=0xFFFFFFFE (wrap-around).
- ADD r0,r4,r4 -> wb_valid=1 and wb_rd=0; a later read of r0 returns 0.
- Illegal op 4'b0101 accepted, one ADD in flight ahead of it -> the ADD commits, err=1 and instr_ready=0 from the next cycle and held; reset clears err and returns to RUN.
- ALU_FWD_EN undefined: ADD r1,..., then ADD r2,r1,r1 -> instr_ready low 2 cycles, and r2 equals 2*r1.
